// File: rtl/ps2_kb_controller.sv
// PS/2 keyboard receive controller: synchronised and filtered line inputs, an 11-bit frame
// deframer with parity, framing and timeout checks, a scan-code FIFO and a CPU register window.
module ps2_kb_controller #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER     = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KB_CLK,
    input  logic       KB_DATA,
    input  logic       CS,
    input  logic [1:0] ADDR,
    input  logic       R,
    input  logic       W,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       INT_N
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]    kc_sync, kd_sync;
    logic          clk_s, data_s, clk_f, flt_hit, bit_ev;
    logic [FW-1:0] fcnt;
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          frm_bad;
    logic [TW-1:0] tcnt;
    logic          push_req, perr_set, ferr_set, tout_set;
    logic          rd_q, rd_qq, wr_q, wr_ev, flush, clr, pop;
    logic          do_push, do_pop, ovr_set, full, avail;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          perr, ferr, ovr, tout, ien;
    logic [7:0]    status;

    assign clk_s = kc_sync[1];
    assign data_s = kd_sync[1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            kc_sync <= 2'b11;
            kd_sync <= 2'b11;
        end else begin
            kc_sync <= {kc_sync[0], KB_CLK};
            kd_sync <= {kd_sync[0], KB_DATA};
        end
    end

    // A new clock level is accepted on the FILTER-th consecutive differing sample.
    assign flt_hit = (clk_s != clk_f) && (fcnt == FW'(FILTER - 1));
    assign bit_ev  = flt_hit && clk_f;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_f <= 1'b1;
            fcnt  <= '0;
        end else if (clk_s == clk_f) begin
            fcnt <= '0;
        end else if (flt_hit) begin
            clk_f <= clk_s;
            fcnt  <= '0;
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end

    always_comb begin
        push_req = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        tout_set = (state != S_IDLE) && !bit_ev && (tcnt == TW'(TIMEOUT));
        if (bit_ev) begin
            case (state)
                S_PARITY: perr_set = ~(^{shreg, data_s});
                S_STOP: begin
                    ferr_set = ~data_s;
                    push_req = data_s & ~frm_bad;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            frm_bad <= 1'b0;
            tcnt    <= '0;
        end else begin
            if (state == S_IDLE || bit_ev || tout_set) tcnt <= '0;
            else tcnt <= tcnt + TW'(1);

            if (tout_set) begin
                state <= S_IDLE;
                shreg <= '0;
            end else if (bit_ev) begin
                case (state)
                    S_IDLE: if (!data_s) begin
                        state   <= S_DATA;
                        bitcnt  <= '0;
                        frm_bad <= 1'b0;
                    end
                    S_DATA: begin
                        shreg  <= {data_s, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        frm_bad <= perr_set;
                        state   <= S_STOP;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // A data-register read pops once, on the cycle after its registered strobe falls.
    assign pop   = rd_qq & ~rd_q & (count != '0);
    assign wr_ev = CS & ~W & ~wr_q & (ADDR == 2'd1);
    assign flush = wr_ev & DIN[1];
    assign clr   = wr_ev & DIN[7];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_q  <= 1'b0;
            rd_qq <= 1'b0;
            wr_q  <= 1'b0;
        end else begin
            rd_q  <= CS & ~R & (ADDR == 2'd0);
            rd_qq <= rd_q;
            wr_q  <= CS & ~W;
        end
    end

    assign full    = (count == CW'(FIFO_DEPTH));
    assign avail   = (count != '0);
    assign do_push = push_req & ~flush & (~full | pop);
    assign do_pop  = pop & ~flush;
    assign ovr_set = push_req & ~flush & full & ~pop;

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= shreg;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Error events take priority over a same-cycle software clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
            tout  <= 1'b0;
            ien   <= 1'b0;
            INT_N <= 1'b1;
        end else begin
            perr  <= perr_set | (perr & ~clr);
            ferr  <= ferr_set | (ferr & ~clr);
            ovr   <= ovr_set | (ovr & ~clr);
            tout  <= tout_set | (tout & ~clr);
            if (wr_ev) ien <= DIN[0];
            INT_N <= ~(ien & (avail | perr | ferr | ovr | tout));
        end
    end

    assign status = {state != S_IDLE, ien, tout, ovr, ferr, perr, full, avail};
    assign DOE    = CS & ~R;

    always_comb begin
        DOUT = 8'h00;
        case (ADDR)
            2'd0:    if (avail) DOUT = mem[rptr];
            2'd1:    DOUT = status;
            2'd2:    DOUT = 8'(count);
            default: DOUT = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_ps2_kb_controller.sv
// Bench for ps2_kb_controller: a table of register/frame vectors plus hand-written corner
// sequences; received scan codes are checked against a queue of expected bytes.
module tb_ps2_kb_controller;
    localparam int H = 20;
    localparam int OP_WR = 0, OP_RD = 1, OP_POP = 2, OP_FRM = 3, OP_INT = 4;

    typedef struct {
        int         op;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    logic       CLK = 1'b0, RST = 1'b0, KB_CLK = 1'b1, KB_DATA = 1'b1;
    logic       CS = 1'b0, R = 1'b1, W = 1'b1;
    logic [1:0] ADDR = 2'd0;
    logic [7:0] DIN = 8'h00;
    logic [7:0] DOUT;
    logic       DOE, INT_N;

    int         vectors = 0, errors = 0;
    logic [7:0] sb [$];
    vec_t       tbl [$];

    ps2_kb_controller dut (
        .CLK(CLK), .RST(RST), .KB_CLK(KB_CLK), .KB_DATA(KB_DATA), .CS(CS), .ADDR(ADDR),
        .R(R), .W(W), .DIN(DIN), .DOUT(DOUT), .DOE(DOE), .INT_N(INT_N)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge CLK);
        CS = 1'b1; R = 1'b0; ADDR = a;
        repeat (2) @(negedge CLK);
        d = DOUT;
        CS = 1'b0; R = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        CS = 1'b1; W = 1'b0; ADDR = a; DIN = d;
        repeat (2) @(negedge CLK);
        CS = 1'b0; W = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop. sync_pop lines up a FIFO pop with the push.
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits,
                              input bit sync_pop);
        logic [10:0] bits;
        bits = {kind != 2, (~^b) ^ (kind == 1), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLK);
            KB_DATA = bits[i];
            if (sync_pop && i == 10) begin
                CS = 1'b1; R = 1'b0; ADDR = 2'd0;
                repeat (H) @(negedge CLK);
                check("pushpop_head", DOUT, sb[0]);
                KB_CLK = 1'b0;
                repeat (4) @(posedge CLK);
                @(negedge CLK);
                CS = 1'b0; R = 1'b1;
                void'(sb.pop_front());
                sb.push_back(b);
                repeat (H - 1) @(negedge CLK);
            end else begin
                repeat (H) @(negedge CLK);
                KB_CLK = 1'b0;
                repeat (H) @(negedge CLK);
            end
            KB_CLK = 1'b1;
        end
        repeat (H) @(negedge CLK);
        KB_DATA = 1'b1;
        repeat (H) @(negedge CLK);
        if (nbits == 11 && kind == 0 && !sync_pop && sb.size() < 8) sb.push_back(b);
    endtask

    task automatic pop_check(input string name);
        logic [7:0] d, e;
        cpu_read(2'd0, d);
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        check(name, d, e);
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] e);
        logic [7:0] d;
        cpu_read(a, d);
        check(name, d, e);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        case (v.op)
            OP_WR:  cpu_write(v.addr, v.data);
            OP_RD:  rd_check(nm, v.addr, v.exp);
            OP_POP: pop_check(nm);
            OP_FRM: send_frame(v.data, int'(v.addr), 11, 1'b0);
            default: check(nm, {7'd0, INT_N}, v.exp);
        endcase
    endtask

    function automatic vec_t mk(input int op, input logic [1:0] a, input logic [7:0] d,
                                input logic [7:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e;
        return v;
    endfunction

    initial begin
        logic [7:0] d;
        // reset state, valid frame, parity error, framing error, ignored writes
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd2, 8'h00, 8'h00));
        tbl.push_back(mk(OP_POP, 2'd0, 8'h00, 8'h00));
        tbl.push_back(mk(OP_INT, 2'd0, 8'h00, 8'h01));
        tbl.push_back(mk(OP_WR, 2'd1, 8'h01, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h40));
        tbl.push_back(mk(OP_INT, 2'd0, 8'h00, 8'h01));
        tbl.push_back(mk(OP_FRM, 2'd0, 8'h1C, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h41));
        tbl.push_back(mk(OP_INT, 2'd0, 8'h00, 8'h00));
        tbl.push_back(mk(OP_POP, 2'd0, 8'h00, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h40));
        tbl.push_back(mk(OP_INT, 2'd0, 8'h00, 8'h01));
        tbl.push_back(mk(OP_FRM, 2'd1, 8'h1C, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h44));
        tbl.push_back(mk(OP_RD, 2'd2, 8'h00, 8'h00));
        tbl.push_back(mk(OP_INT, 2'd0, 8'h00, 8'h00));
        tbl.push_back(mk(OP_WR, 2'd1, 8'h81, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h40));
        tbl.push_back(mk(OP_FRM, 2'd2, 8'h33, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h48));
        tbl.push_back(mk(OP_RD, 2'd2, 8'h00, 8'h00));
        tbl.push_back(mk(OP_WR, 2'd1, 8'h81, 8'h00));
        tbl.push_back(mk(OP_FRM, 2'd0, 8'h5A, 8'h00));
        tbl.push_back(mk(OP_POP, 2'd0, 8'h00, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h40));
        tbl.push_back(mk(OP_WR, 2'd0, 8'hFE, 8'h00));
        tbl.push_back(mk(OP_WR, 2'd3, 8'hFE, 8'h00));
        tbl.push_back(mk(OP_RD, 2'd1, 8'h00, 8'h40));
        tbl.push_back(mk(OP_RD, 2'd3, 8'h00, 8'h00));

        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("doe_idle", {7'd0, DOE}, 8'h00);
        for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

        // overrun: nine frames, no reads
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11, 1'b0);
        rd_check("ovr_count", 2'd2, 8'h08);
        rd_check("ovr_status", 2'd1, 8'h53);
        check("ovr_int", {7'd0, INT_N}, 8'h00);
        for (int i = 0; i < 9; i++) pop_check($sformatf("ovr_pop%0d", i));
        rd_check("ovr_drained", 2'd1, 8'h50);
        cpu_write(2'd1, 8'h81);
        rd_check("ovr_clr", 2'd1, 8'h40);

        // timeout after a partial frame
        send_frame(8'hA5, 0, 5, 1'b0);
        rd_check("tout_busy", 2'd1, 8'hC0);
        repeat (4300) @(negedge CLK);
        rd_check("tout_status", 2'd1, 8'h60);
        check("tout_int", {7'd0, INT_N}, 8'h00);
        cpu_write(2'd1, 8'h81);
        send_frame(8'h29, 0, 11, 1'b0);
        pop_check("tout_next");

        // short clock glitch with data low must not start a frame
        @(negedge CLK);
        KB_DATA = 1'b0; KB_CLK = 1'b0;
        repeat (2) @(negedge CLK);
        KB_CLK = 1'b1;
        repeat (4) @(negedge CLK);
        KB_DATA = 1'b1;
        repeat (10) @(negedge CLK);
        rd_check("glitch", 2'd1, 8'h40);

        // push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 11, 1'b0);
        rd_check("full_status", 2'd1, 8'h43);
        send_frame(8'h77, 0, 11, 1'b1);
        repeat (4) @(negedge CLK);
        rd_check("pushpop_count", 2'd2, 8'h08);
        rd_check("pushpop_status", 2'd1, 8'h43);
        pop_check("pushpop_next");
        cpu_write(2'd1, 8'h03);
        sb.delete();
        rd_check("flush_count", 2'd2, 8'h00);
        rd_check("flush_status", 2'd1, 8'h40);
        pop_check("flush_empty");

        // asynchronous reset in the middle of a frame
        send_frame(8'h3C, 0, 11, 1'b0);
        check("pre_rst_int", {7'd0, INT_N}, 8'h00);
        send_frame(8'hC3, 0, 5, 1'b0);
        #2 RST = 1'b0;
        #1 check("rst_int", {7'd0, INT_N}, 8'h01);
        CS = 1'b1; R = 1'b0; ADDR = 2'd1;
        #1 check("rst_status", DOUT, 8'h00);
        check("rst_doe", {7'd0, DOE}, 8'h01);
        ADDR = 2'd2;
        #1 check("rst_count", DOUT, 8'h00);
        ADDR = 2'd0;
        #1 check("rst_head", DOUT, 8'h00);
        CS = 1'b0; R = 1'b1;
        sb.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        send_frame(8'h5C, 0, 11, 1'b0);
        rd_check("post_rst_status", 2'd1, 8'h01);
        check("post_rst_int", {7'd0, INT_N}, 8'h01);
        pop_check("post_rst_pop");
        cpu_read(2'd2, d);
        check("post_rst_count", d, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
